// File: rtl/local_pattern_history_table.sv
// Local branch predictor pattern history table: 2-bit saturating counters indexed by local history,
// with a registered lookup, single-edge training and a multi-cycle flush sweep. Optional macro: LOCAL_PHT_BYPASS_EN.
module local_pattern_history_table #(
    parameter int HIST_W = 4,
    parameter int CTR_W  = 2,
    parameter logic [CTR_W-1:0] CTR_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [HIST_W-1:0] rd_his,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [CTR_W-1:0]  pred_ctr,
    input  logic              upd_en,
    input  logic [HIST_W-1:0] upd_his,
    input  logic              upd_taken,
    input  logic              flush_req,
    output logic              ready
);

    localparam int DEPTH = 1 << HIST_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t             state_reg;
    logic [HIST_W-1:0]  flush_idx_reg;
    logic               ready_reg;
    logic               pred_valid_reg;
    logic [CTR_W-1:0]   pred_ctr_reg;

    logic [CTR_W-1:0]   ctr_vec [DEPTH];
    logic               rd_fire;
    logic               upd_fire;
    logic               flush_wr;
    logic [CTR_W-1:0]   upd_cur;
    logic [CTR_W-1:0]   upd_next;
    logic [CTR_W-1:0]   rd_value;

    // Lookups and training are only honoured outside the flush sweep.
    assign rd_fire  = rd_en & ready_reg;
    assign upd_fire = upd_en & ready_reg;
    assign flush_wr = (state_reg == ST_FLUSH);
    assign upd_cur  = ctr_vec[upd_his];

    always_comb begin
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) upd_next = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_next = upd_cur - 1'b1;
        end
    end

    always_comb begin
        rd_value = ctr_vec[rd_his];
`ifdef LOCAL_PHT_BYPASS_EN
        // Forward the training result so a same-edge lookup sees the new count.
        if (upd_fire && (upd_his == rd_his)) rd_value = upd_next;
`endif
    end

    // Counters live in flops so the whole table returns to CTR_INIT on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [CTR_W-1:0] ctr_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctr_reg <= CTR_INIT;
                end else if (flush_wr && (flush_idx_reg == HIST_W'(gi))) begin
                    ctr_reg <= CTR_INIT;
                end else if (upd_fire && (upd_his == HIST_W'(gi))) begin
                    ctr_reg <= upd_next;
                end
            end
            assign ctr_vec[gi] = ctr_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            flush_idx_reg <= '0;
            ready_reg     <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_reg     <= ST_FLUSH;
                        flush_idx_reg <= '0;
                        ready_reg     <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    flush_idx_reg <= flush_idx_reg + 1'b1;
                    if (&flush_idx_reg) begin
                        state_reg <= ST_IDLE;
                        ready_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_reg <= 1'b0;
            pred_ctr_reg   <= '0;
        end else begin
            pred_valid_reg <= rd_fire;
            if (rd_fire) pred_ctr_reg <= rd_value;
        end
    end

    assign pred_valid = pred_valid_reg;
    assign pred_ctr   = pred_ctr_reg;
    assign pred_taken = pred_ctr_reg[CTR_W-1];
    assign ready      = ready_reg;

endmodule

// File: tb/tb_local_pattern_history_table.sv
// Directed bench for local_pattern_history_table: a counter-array model checked every cycle plus literal expectations.
module tb_local_pattern_history_table;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_his = '0;
    logic       pred_valid;
    logic       pred_taken;
    logic [1:0] pred_ctr;
    logic       upd_en = 1'b0;
    logic [3:0] upd_his = '0;
    logic       upd_taken = 1'b0;
    logic       flush_req = 1'b0;
    logic       ready;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: plain integer counters and a countdown of remaining flush cycles.
    int m_tab [16];
    int m_valid = 0;
    int m_ctr = 0;
    int m_busy_left = 0;
    int m_nv;

    always #5 clk = ~clk;

    local_pattern_history_table dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_his     (rd_his),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ctr   (pred_ctr),
        .upd_en     (upd_en),
        .upd_his    (upd_his),
        .upd_taken  (upd_taken),
        .flush_req  (flush_req),
        .ready      (ready)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_tab[i] = 1;
            m_valid = 0;
            m_ctr = 0;
            m_busy_left = 0;
        end else if (m_busy_left > 0) begin
            m_tab[16 - m_busy_left] = 1;
            m_busy_left--;
            m_valid = 0;
        end else begin
            m_nv = upd_taken ? ((m_tab[upd_his] >= 3) ? 3 : m_tab[upd_his] + 1)
                             : ((m_tab[upd_his] <= 0) ? 0 : m_tab[upd_his] - 1);
            if (rd_en) begin
                m_valid = 1;
                m_ctr = m_tab[rd_his];
`ifdef LOCAL_PHT_BYPASS_EN
                if (upd_en && (upd_his == rd_his)) m_ctr = m_nv;
`endif
            end else begin
                m_valid = 0;
            end
            if (upd_en) m_tab[upd_his] = m_nv;
            if (flush_req) m_busy_left = 16;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", int'(ready), (m_busy_left == 0) ? 1 : 0);
            check("pred_valid", int'(pred_valid), m_valid);
            check("pred_ctr", int'(pred_ctr), m_ctr);
            check("pred_taken", int'(pred_taken), m_ctr / 2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [3:0] h, input int exp_ctr, input string name);
        rd_en = 1'b1;
        rd_his = h;
        step();
        rd_en = 1'b0;
        $display("lookup  his=%h ctr=%0d valid=%0d", h, pred_ctr, pred_valid);
        if (exp_ctr >= 0) begin
            check({name, "_valid"}, int'(pred_valid), 1);
            check({name, "_ctr"}, int'(pred_ctr), exp_ctr);
            check({name, "_taken"}, int'(pred_taken), exp_ctr / 2);
        end
    endtask

    task automatic update(input logic [3:0] h, input logic t, input int n);
        for (int k = 0; k < n; k++) begin
            upd_en = 1'b1;
            upd_his = h;
            upd_taken = t;
            step();
            upd_en = 1'b0;
            $display("update  his=%h taken=%0d", h, t);
        end
    endtask

    int cnt;
    int exp_byp;

    initial begin
        rst_n = 1'b0;
        step();
        step();
        check("reset_ready", int'(ready), 1);
        check("reset_valid", int'(pred_valid), 0);
        check("reset_ctr", int'(pred_ctr), 0);
        rst_n = 1'b1;
        step();

        lookup(4'h5, 1, "init5");
        update(4'h5, 1'b1, 3);
        lookup(4'h5, 3, "sat5");
        update(4'h5, 1'b1, 1);
        lookup(4'h5, 3, "sat5_again");

        update(4'h3, 1'b0, 4);
        lookup(4'h3, 0, "floor3");
        lookup(4'h4, 1, "neigh4");

        // Entry 9 to weakly taken, then same-edge lookup + taken update.
        update(4'h9, 1'b1, 1);
`ifdef LOCAL_PHT_BYPASS_EN
        exp_byp = 3;
`else
        exp_byp = 2;
`endif
        upd_en = 1'b1;
        upd_his = 4'h9;
        upd_taken = 1'b1;
        lookup(4'h9, exp_byp, "same_edge9");
        upd_en = 1'b0;
        lookup(4'h9, 3, "after9");

        update(4'h0, 1'b1, 2);
        update(4'hF, 1'b1, 2);

        // Flush requested on the same edge as a lookup: the lookup still completes.
        flush_req = 1'b1;
        lookup(4'h0, 3, "flush_edge0");
        flush_req = 1'b0;
        check("flush_ready_drop", int'(ready), 0);

        rd_en = 1'b1;
        rd_his = 4'hF;
        upd_en = 1'b1;
        upd_his = 4'h3;
        upd_taken = 1'b1;
        cnt = 1;
        while (ready == 1'b0 && cnt < 100) begin
            step();
            if (ready == 1'b0) cnt++;
        end
        rd_en = 1'b0;
        upd_en = 1'b0;
        $display("flush   busy_cycles=%0d", cnt);
        check("flush_len", cnt, 16);
        check("flush_no_valid", int'(pred_valid), 0);

        lookup(4'h0, 1, "post_flush0");
        lookup(4'hF, 1, "post_flushF");
        lookup(4'h3, 1, "post_flush3");

        // Reset in the middle of a sweep.
        update(4'hA, 1'b1, 2);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int k = 0; k < 6; k++) step();
        rst_n = 1'b0;
        #2;
        check("midflush_reset_ready", int'(ready), 1);
        step();
        rst_n = 1'b1;
        check("after_reset_ready", int'(ready), 1);
        for (int i = 0; i < 16; i++) begin
            lookup(4'(i), 1, "reset_sweep");
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
